// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Signed saturating MAC back-end for the combinational Booth multiplier.
// Sums a frame of up to LEN signed 2*WIDTH-bit products into an ACC_WIDTH
// accumulator. Every step is clamped to the signed ACC_WIDTH range, so there
// is no wrap-around. The frame result is offered on a valid/ready port.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    in_product / in_last are valid
//   in_ready    block accepts a product this cycle (high in ACCUM)
//   in_product  signed product, 2*WIDTH bits
//   in_last     accepted product closes the frame early
//   out_valid   frame result available (high in HOLD)
//   out_ready   downstream takes the result
//   out_sum     signed saturated frame sum, ACC_WIDTH bits
//   out_count   number of products in the frame
//   out_sat     clamping happened at least once in the frame
// -----------------------------------------------------------------------------
module product_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,   // must be >= 2*WIDTH
  parameter int LEN       = 4     // must be >= 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2*WIDTH-1:0]           in_product,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_WIDTH-1:0]         out_sum,
  output logic [$clog2(LEN+1)-1:0]     out_count,
  output logic                         out_sat
);

  localparam int PW  = 2 * WIDTH;
  localparam int CW  = $clog2(LEN + 1);
  localparam int EXT = ACC_WIDTH + 1 - PW;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q,   acc_d;
  logic [CW-1:0]         cnt_q,   cnt_d;
  logic                  sat_q,   sat_d;

  logic                  accept;
  logic [ACC_WIDTH:0]    sum_ext;
  logic                  overflow;
  logic [ACC_WIDTH-1:0]  clamped;
  logic [CW-1:0]         cnt_inc;
  logic                  last_beat;

  // Add in ACC_WIDTH+1 bits: two's-complement addition needs no signed
  // types once both operands are sign-extended by hand.
  assign sum_ext  = {acc_q[ACC_WIDTH-1], acc_q}
                  + {{EXT{in_product[PW-1]}}, in_product};
  // The extra top bit disagrees with the ACC_WIDTH sign bit only when the
  // true sum falls outside the representable range.
  assign overflow = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];
  assign clamped  = overflow ? (sum_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                             : sum_ext[ACC_WIDTH-1:0];

  assign accept    = in_valid && (state_q == ACCUM);
  // cnt_q < LEN while accumulating, so the increment cannot overflow CW bits.
  assign cnt_inc   = cnt_q + 1'b1;
  assign last_beat = (cnt_inc == CW'(LEN)) || in_last;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = clamped;
          cnt_d = cnt_inc;
          sat_d = sat_q | overflow;
          if (last_beat) state_d = HOLD;
        end
      end
      HOLD: begin
        // Result handed over: start the next frame from zero on this edge.
        if (out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  // Outputs come straight from registers, so they cannot glitch in HOLD.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_product_accumulator
//
// Directed self-checking bench for product_accumulator with WIDTH=8,
// ACC_WIDTH=16, LEN=4. Inputs change on the falling edge, outputs are
// sampled on the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_product_accumulator;

  localparam int WIDTH     = 8;
  localparam int ACC_WIDTH = 16;
  localparam int LEN       = 4;
  localparam int CW        = $clog2(LEN + 1);

  logic                        clk;
  logic                        rst_n;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [2*WIDTH-1:0]   in_product;
  logic                        in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [ACC_WIDTH-1:0] out_sum;
  logic [CW-1:0]               out_count;
  logic                        out_sat;

  int tests_run    = 0;
  int tests_failed = 0;

  product_accumulator #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .LEN       (LEN)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_count  (out_count),
    .out_sat    (out_sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Present one product for one cycle; it must be accepted on the next edge.
  task automatic send(input logic signed [15:0] p, input logic last);
    @(negedge clk);
    check("in_ready_before_accept", 32'(in_ready), 1);
    in_valid   = 1'b1;
    in_product = p;
    in_last    = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the closing accept: result must be up on this cycle.
  task automatic expect_result(input string tag, input int sum, input int cnt,
                               input int sat);
    @(negedge clk);
    check({tag, "_out_valid"}, 32'(out_valid), 1);
    check({tag, "_in_ready"},  32'(in_ready),  0);
    check({tag, "_sum"},       32'(out_sum),   sum);
    check({tag, "_count"},     32'(out_count), cnt);
    check({tag, "_sat"},       32'(out_sat),   sat);
    if (out_ready) begin
      @(negedge clk);
      check({tag, "_valid_drop"}, 32'(out_valid), 0);
      check({tag, "_ready_back"}, 32'(in_ready),  1);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_product = '0;
    in_last    = 1'b0;
    out_ready  = 1'b1;

    // Reset state.
    #12;
    check("rst_in_ready",  32'(in_ready),  1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_sum",       32'(out_sum),   0);
    check("rst_count",     32'(out_count), 0);
    check("rst_sat",       32'(out_sat),   0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame: 100 - 50 + 25 + 7 = 82, closed by reaching LEN.
    send(16'sd100, 1'b0);
    send(-16'sd50, 1'b0);
    send(16'sd25,  1'b0);
    send(16'sd7,   1'b0);
    expect_result("basic", 82, 4, 0);

    // Positive saturation: 32768 clamps to 32767, then -100 -> 32667.
    send(16'sd16384, 1'b0);
    send(16'sd16384, 1'b0);
    send(-16'sd100,  1'b0);
    send(16'sd0,     1'b0);
    expect_result("pos_sat", 32667, 4, 1);

    // Negative saturation: -48768 clamps to -32768, then +1 -> -32767.
    send(-16'sd16256, 1'b0);
    send(-16'sd16256, 1'b0);
    send(-16'sd16256, 1'b0);
    send(16'sd1,      1'b0);
    expect_result("neg_sat", -32767, 4, 1);

    // Early close with in_last.
    send(16'sd10, 1'b0);
    send(-16'sd3, 1'b1);
    expect_result("early", 7, 2, 0);

    // Next frame starts from zero; idle cycles (with a stray in_last while
    // in_valid is low) neither count nor close the frame.
    send(16'sd5, 1'b0);
    @(negedge clk);
    in_last = 1'b1;
    @(negedge clk);
    in_last = 1'b0;
    check("idle_no_close", 32'(out_valid), 0);
    check("idle_count",    32'(out_count), 1);
    send(16'sd6, 1'b1);
    expect_result("after_idle", 11, 2, 0);

    // Backpressure: result held, inputs refused while out_ready is low.
    out_ready = 1'b0;
    send(16'sd1, 1'b0);
    send(16'sd2, 1'b0);
    send(16'sd3, 1'b0);
    send(16'sd4, 1'b0);
    expect_result("bp_frame", 10, 4, 0);
    for (int k = 0; k < 5; k++) begin
      in_valid   = 1'b1;
      in_product = 16'(100 * (k + 1));
      in_last    = k[0];
      @(negedge clk);
      check("bp_in_ready",  32'(in_ready),  0);
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_sum",       32'(out_sum),   10);
      check("bp_count",     32'(out_count), 4);
      check("bp_sat",       32'(out_sat),   0);
    end
    // Handshake edge: the product offered alongside it must not be taken.
    in_product = 16'sd500;
    in_last    = 1'b0;
    out_ready  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_released",   32'(out_valid), 0);
    check("bp_cleared",    32'(out_count), 0);
    send(16'sd7, 1'b0);
    send(16'sd8, 1'b1);
    expect_result("bp_next", 15, 2, 0);

    // Asynchronous reset mid-frame, between clock edges.
    send(16'sd1, 1'b0);
    send(16'sd2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  32'(in_ready),  1);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_sum",       32'(out_sum),   0);
    check("mid_rst_count",     32'(out_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(16'sd1, 1'b0);
    send(16'sd2, 1'b0);
    send(16'sd3, 1'b0);
    send(16'sd4, 1'b0);
    expect_result("post_rst", 10, 4, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
